// File: rtl/pong_ball_engine.sv
// Registered pong ball engine: owns ball position, direction, serve delay,
// scores and game-over, advancing once per frame_tick and emitting event pulses.
module pong_ball_engine #(
  parameter int W            = 11,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 64,
  parameter int PAD_L_X      = 16,
  parameter int PAD_R_X      = 616,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [W-1:0]       pad_l_y,
  input  logic [W-1:0]       pad_r_y,
  output logic [W-1:0]       ball_x,
  output logic [W-1:0]       ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               hit_l,
  output logic               hit_r,
  output logic               wall_hit,
  output logic               point_l,
  output logic               point_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int CNT_W      = $clog2(SERVE_FRAMES + 1);
  localparam int CX_I       = (SCREEN_W - BALL_SIZE) / 2;
  localparam int CY_I       = (SCREEN_H - BALL_SIZE) / 2;
  localparam int PAD_L_EDGE = PAD_L_X + PAD_W;
  localparam int PAD_R_STOP = PAD_R_X - BALL_SIZE;
  localparam int FLOOR_Y    = SCREEN_H - BALL_SIZE;
  localparam int SERVE_LAST = SERVE_FRAMES - 1;

  localparam logic [W-1:0]       CX         = CX_I[W-1:0];
  localparam logic [W-1:0]       CY         = CY_I[W-1:0];
  localparam logic [W-1:0]       X_L_STOP   = PAD_L_EDGE[W-1:0];
  localparam logic [W-1:0]       X_R_STOP   = PAD_R_STOP[W-1:0];
  localparam logic [CNT_W-1:0]   CNT_LAST   = SERVE_LAST[CNT_W-1:0];
  localparam logic [SCORE_W-1:0] K_WIN      = WIN_SCORE[SCORE_W-1:0];

  // One extra bit of headroom so sums like x+BALL_SIZE never wrap.
  localparam logic [W:0] K_SPD   = SPEED[W:0];
  localparam logic [W:0] K_BS    = BALL_SIZE[W:0];
  localparam logic [W:0] K_SW    = SCREEN_W[W:0];
  localparam logic [W:0] K_SH    = SCREEN_H[W:0];
  localparam logic [W:0] K_PH    = PAD_H[W:0];
  localparam logic [W:0] K_PRX   = PAD_R_X[W:0];
  localparam logic [W:0] K_PLE   = PAD_L_EDGE[W:0];
  localparam logic [W:0] K_FLOOR = FLOOR_Y[W:0];

  state_t             state_q, state_d;
  logic [W-1:0]       ball_x_q, ball_x_d;
  logic [W-1:0]       ball_y_q, ball_y_d;
  logic               dir_x_q, dir_x_d;
  logic               dir_y_q, dir_y_d;
  logic               hit_l_q, hit_l_d;
  logic               hit_r_q, hit_r_d;
  logic               wall_hit_q, wall_hit_d;
  logic               point_l_q, point_l_d;
  logic               point_r_q, point_r_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               game_over_q, game_over_d;
  logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;

  logic [W:0]         x_e, y_e, pl_e, pr_e;
  logic [W:0]         nx_raw, ny_raw, ny_c;
  logic               dir_y_n, y_bounce;
  logic               r_hit, l_hit, miss_l, miss_r;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic               win_now;

  // Frame geometry: candidate move, wall clamp, paddle and miss detection.
  always_comb begin
    x_e    = {1'b0, ball_x_q};
    y_e    = {1'b0, ball_y_q};
    pl_e   = {1'b0, pad_l_y};
    pr_e   = {1'b0, pad_r_y};
    nx_raw = dir_x_q ? (x_e + K_SPD) : (x_e - K_SPD);
    ny_raw = dir_y_q ? (y_e + K_SPD) : (y_e - K_SPD);

    ny_c     = ny_raw;
    dir_y_n  = dir_y_q;
    y_bounce = 1'b0;
    if (dir_y_q && (ny_raw + K_BS >= K_SH)) begin
      ny_c     = K_FLOOR;
      dir_y_n  = 1'b0;
      y_bounce = 1'b1;
    end else if (!dir_y_q && (y_e < K_SPD)) begin
      ny_c     = '0;
      dir_y_n  = 1'b1;
      y_bounce = 1'b1;
    end

    r_hit = dir_x_q && (x_e + K_BS <= K_PRX) && (nx_raw + K_BS >= K_PRX) &&
            (ny_c + K_BS > pr_e) && (ny_c < pr_e + K_PH);
    l_hit = !dir_x_q && (x_e >= K_PLE) && (nx_raw <= K_PLE) &&
            (ny_c + K_BS > pl_e) && (ny_c < pl_e + K_PH);

    miss_l = dir_x_q && !r_hit && (nx_raw + K_BS >= K_SW);
    miss_r = !dir_x_q && !l_hit && (x_e < K_SPD);

    score_l_inc = (score_l_q == K_WIN) ? score_l_q : score_l_q + 1'b1;
    score_r_inc = (score_r_q == K_WIN) ? score_r_q : score_r_q + 1'b1;
    win_now     = (miss_l && (score_l_inc == K_WIN)) ||
                  (miss_r && (score_r_inc == K_WIN));
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    game_over_d = game_over_q;
    serve_cnt_d = serve_cnt_q;
    hit_l_d     = 1'b0;
    hit_r_d     = 1'b0;
    wall_hit_d  = 1'b0;
    point_l_d   = 1'b0;
    point_r_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          serve_cnt_d = '0;
        end
      end

      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == CNT_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          wall_hit_d = y_bounce;
          hit_r_d    = r_hit;
          hit_l_d    = l_hit;
          dir_y_d    = dir_y_n;
          if (miss_l || miss_r) begin
            // Re-serve from centre toward the player who conceded.
            ball_x_d    = CX;
            ball_y_d    = CY;
            dir_x_d     = miss_l;
            serve_cnt_d = '0;
            point_l_d   = miss_l;
            point_r_d   = miss_r;
            if (miss_l) score_l_d = score_l_inc;
            else        score_r_d = score_r_inc;
            if (win_now) begin
              state_d     = ST_OVER;
              game_over_d = 1'b1;
            end else begin
              state_d = ST_SERVE;
            end
          end else begin
            ball_y_d = ny_c[W-1:0];
            if (r_hit) begin
              ball_x_d = X_R_STOP;
              dir_x_d  = 1'b0;
            end else if (l_hit) begin
              ball_x_d = X_L_STOP;
              dir_x_d  = 1'b1;
            end else begin
              ball_x_d = nx_raw[W-1:0];
            end
          end
        end
      end

      ST_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          score_l_d   = '0;
          score_r_d   = '0;
          game_over_d = 1'b0;
          dir_x_d     = 1'b1;
          serve_cnt_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      hit_l_q     <= 1'b0;
      hit_r_q     <= 1'b0;
      wall_hit_q  <= 1'b0;
      point_l_q   <= 1'b0;
      point_r_q   <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
      serve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      hit_l_q     <= hit_l_d;
      hit_r_q     <= hit_r_d;
      wall_hit_q  <= wall_hit_d;
      point_l_q   <= point_l_d;
      point_r_q   <= point_r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      game_over_q <= game_over_d;
      serve_cnt_q <= serve_cnt_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign hit_l     = hit_l_q;
  assign hit_r     = hit_r_q;
  assign wall_hit  = wall_hit_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: directed game scenarios plus randomized play,
// every cycle compared against an integer-arithmetic model of the game rules.
module tb_pong_ball_engine;

  localparam int SW = 640, SH = 480, BS = 8, PW = 8, PH = 64;
  localparam int PLX = 16, PRX = 616, SPD = 2, SERVE = 60, WIN = 9;
  localparam int CX = (SW - BS) / 2, CY = (SH - BS) / 2;

  logic        clk = 1'b0;
  logic        reset, frame_tick, start;
  logic [10:0] pad_l_y, pad_r_y;
  logic [10:0] ball_x, ball_y;
  logic        dir_x, dir_y, hit_l, hit_r, wall_hit, point_l, point_r, game_over;
  logic [3:0]  score_l, score_r;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_ball_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .ball_x(ball_x), .ball_y(ball_y),
    .dir_x(dir_x), .dir_y(dir_y), .hit_l(hit_l), .hit_r(hit_r),
    .wall_hit(wall_hit), .point_l(point_l), .point_r(point_r),
    .score_l(score_l), .score_r(score_r), .game_over(game_over), .state(state)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: game rules in plain integer arithmetic.
  int m_st, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_go;
  int m_hl, m_hr, m_wh, m_pl, m_pr;

  task automatic model_reset();
    m_st = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_sl = 0; m_sr = 0; m_cnt = 0; m_go = 0;
    m_hl = 0; m_hr = 0; m_wh = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_step();
    int nx, ny, ndx, ndy, pl, pr, sc;
    bit miss;
    m_hl = 0; m_hr = 0; m_wh = 0; m_pl = 0; m_pr = 0;
    pl = int'(pad_l_y);
    pr = int'(pad_r_y);
    case (m_st)
      0: if (start) begin m_st = 1; m_sl = 0; m_sr = 0; m_cnt = 0; end
      1: if (frame_tick) begin
        m_cnt++;
        if (m_cnt == SERVE) begin m_st = 2; m_cnt = 0; end
      end
      2: if (frame_tick) begin
        nx = m_dx ? m_x + SPD : m_x - SPD;
        ny = m_dy ? m_y + SPD : m_y - SPD;
        ndx = m_dx; ndy = m_dy; miss = 0; sc = 0;
        if (m_dy == 1 && ny + BS >= SH) begin ny = SH - BS; ndy = 0; m_wh = 1; end
        else if (m_dy == 0 && m_y < SPD) begin ny = 0; ndy = 1; m_wh = 1; end
        if (m_dx == 1 && m_x + BS <= PRX && nx + BS >= PRX && ny + BS > pr && ny < pr + PH) begin
          nx = PRX - BS; ndx = 0; m_hr = 1;
        end else if (m_dx == 0 && m_x >= PLX + PW && nx <= PLX + PW && ny + BS > pl && ny < pl + PH) begin
          nx = PLX + PW; ndx = 1; m_hl = 1;
        end else if (m_dx == 1 && nx + BS >= SW) begin
          m_pl = 1; miss = 1; m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; sc = m_sl;
        end else if (m_dx == 0 && m_x < SPD) begin
          m_pr = 1; miss = 1; m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; sc = m_sr;
        end
        if (miss) begin
          m_x = CX; m_y = CY; m_dx = m_pl; m_dy = ndy; m_cnt = 0;
          if (sc == WIN) begin m_st = 3; m_go = 1; end
          else m_st = 1;
        end else begin
          m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        end
      end
      default: if (start) begin
        m_st = 1; m_sl = 0; m_sr = 0; m_go = 0; m_dx = 1; m_cnt = 0;
      end
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  function automatic logic [39:0] model_vec();
    return {11'(m_x), 11'(m_y), 1'(m_dx), 1'(m_dy), 1'(m_hl), 1'(m_hr), 1'(m_wh),
            1'(m_pl), 1'(m_pr), 4'(m_sl), 4'(m_sr), 1'(m_go), 2'(m_st)};
  endfunction

  logic [39:0] dut_vec;
  assign dut_vec = {ball_x, ball_y, dir_x, dir_y, hit_l, hit_r, wall_hit,
                    point_l, point_r, score_l, score_r, game_over, state};

  always @(negedge clk) chk("cycle", 64'(dut_vec), 64'(model_vec()));

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pad_l_y = '0; pad_r_y = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_bx", 64'(ball_x), 64'(CX));
    chk("rst_by", 64'(ball_y), 64'(CY));
    chk("rst_dir", 64'({dir_x, dir_y}), 64'(2'b11));
    chk("rst_st", 64'(state), 64'(0));
    chk("rst_sc", 64'({score_l, score_r, game_over}), 64'(0));
    chk("rst_pulse", 64'({hit_l, hit_r, wall_hit, point_l, point_r}), 64'(0));
    reset = 1'b0;

    // Serve hold, first move, wall bounce, left point
    pulse_start();
    chk("serve_st", 64'(state), 64'(1));
    tk(59);
    chk("hold_bx", 64'(ball_x), 64'(316));
    chk("hold_st", 64'(state), 64'(1));
    tk(1);
    chk("play_st", 64'(state), 64'(2));
    chk("play_bx", 64'(ball_x), 64'(316));
    tk(1);
    chk("mv1", 64'({ball_x, ball_y}), 64'({11'd318, 11'd238}));
    tk(117);
    chk("wall_by", 64'(ball_y), 64'(472));
    chk("wall_dy", 64'(dir_y), 64'(0));
    chk("wall_hit", 64'(wall_hit), 64'(1));
    chk("wall_bx", 64'(ball_x), 64'(552));
    @(negedge clk);
    chk("wall_1cyc", 64'(wall_hit), 64'(0));
    tk(40);
    chk("pt_l", 64'(point_l), 64'(1));
    chk("pt_sl", 64'(score_l), 64'(1));
    chk("pt_ball", 64'({ball_x, ball_y}), 64'({11'd316, 11'd236}));
    chk("pt_dx", 64'(dir_x), 64'(1));
    chk("pt_st", 64'(state), 64'(1));

    // Right paddle bounce
    do_reset();
    pad_r_y = 11'd400;
    pulse_start();
    tk(60);
    tk(146);
    chk("hr_ball", 64'({ball_x, ball_y}), 64'({11'd608, 11'd416}));
    chk("hr_dx", 64'(dir_x), 64'(0));
    chk("hr_pulse", 64'(hit_r), 64'(1));
    chk("hr_nopt", 64'(point_l), 64'(0));

    // Nine left-player points end the game
    do_reset();
    pad_r_y = '0;
    pulse_start();
    for (int c = 0; c < 20000 && state != 2'd3; c++) begin
      pad_r_y = (ball_y < 11'd200) ? 11'd400 : 11'd0;
      frame_tick = 1'b1;
      @(negedge clk);
    end
    frame_tick = 1'b0;
    chk("over_st", 64'(state), 64'(3));
    chk("over_sc", 64'({score_l, score_r}), 64'({4'd9, 4'd0}));
    chk("over_go", 64'(game_over), 64'(1));
    tk(10);
    chk("over_hold", 64'({state, score_l, ball_x, ball_y}), 64'({2'd3, 4'd9, 11'd316, 11'd236}));
    pulse_start();
    chk("restart", 64'({state, score_l, score_r, game_over, dir_x}), 64'({2'd1, 4'd0, 4'd0, 1'b0, 1'b1}));

    // Asynchronous reset mid-play, after a point has been scored
    do_reset();
    pad_r_y = '0;
    pulse_start();
    tk(60 + 158 + 70);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_ball", 64'({ball_x, ball_y, dir_x, dir_y}), 64'({11'd316, 11'd236, 2'b11}));
    chk("arst_st", 64'({state, score_l, score_r, game_over}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst_rel", 64'({score_l, score_r}), 64'(0));

    // Randomized play
    for (int i = 0; i < 20000; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      start      = ($urandom_range(0, 199) == 0);
      reset      = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 1) == 1) begin
        pad_l_y = (ball_y > 11'd30) ? ball_y - 11'd30 : 11'd0;
        pad_r_y = (ball_y > 11'd30) ? ball_y - 11'd30 : 11'd0;
      end else begin
        pad_l_y = 11'($urandom_range(0, 479));
        pad_r_y = 11'($urandom_range(0, 479));
      end
      @(negedge clk);
    end
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Registered, parametrised successor to the combinational edge/collision detector. It owns the ball state: position, direction, serve delay, score and game-over. Once per frame it advances the ball, bounces it off the walls and both paddles, detects misses, and emits one-cycle event pulses. It sits between the paddle controllers and the VGA renderer, and is clocked by the pixel clock with a per-frame enable.

Parameters:
W, 11, coordinate width (unsigned)
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 8, ball edge length (square ball)
PAD_W, 8, paddle width
PAD_H, 64, paddle height
PAD_L_X, 16, left paddle x (left edge)
PAD_R_X, 616, right paddle x (left edge)
SPEED, 2, pixels moved per frame on each axis
SERVE_FRAMES, 60, frames the ball is held at centre before play
SCORE_W, 4, score counter width
WIN_SCORE, 9, score that ends the game

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per frame
start  in  1  level; begins a game from IDLE or OVER
pad_l_y  in  W  left paddle top y
pad_r_y  in  W  right paddle top y
ball_x  out  W  ball left x
ball_y  out  W  ball top y
dir_x  out  1  1 = moving right (+x)
dir_y  out  1  1 = moving down (+y)
hit_l, hit_r  out  1  paddle-bounce pulses
wall_hit  out  1  top/bottom bounce pulse
point_l, point_r  out  1  point-scored pulses (left/right player)
score_l, score_r  out  SCORE_W  scores
game_over  out  1  high in OVER
state  out  2  IDLE=0, SERVE=1, PLAY=2, OVER=3

Behaviour:
- One clock; reset is asynchronous and active-high. While reset is high, outputs are forced immediately, with no clock edge needed:
  - ball at centre: CX=(SCREEN_W-BALL_SIZE)/2, CY=(SCREEN_H-BALL_SIZE)/2.
  - dir_x=1, dir_y=1.
  - scores 0, all pulses 0, game_over 0, state IDLE.
- All outputs are registered. Pulses are high for exactly the one cycle after the edge that sampled frame_tick=1.
- frame_tick is ignored in IDLE and OVER. Paddle y inputs are sampled only on frame_tick edges.
- IDLE: start=1 -> SERVE; clear scores and the serve counter.
- SERVE: ball held at (CX,CY). Count frame_ticks. The edge that samples the SERVE_FRAMES-th tick enters PLAY without moving the ball.
- PLAY, on each frame_tick: nx = x±SPEED, ny = y±SPEED, per dir. All checks use the current x/y and nx/ny.
  - Y axis:
    - dir_y=1 and ny+BALL_SIZE>=SCREEN_H: ny=SCREEN_H-BALL_SIZE, dir_y<=0, wall_hit.
    - dir_y=0 and y<SPEED (compare before subtracting, so no wrap): ny=0, dir_y<=1, wall_hit.
  - Right paddle: dir_x=1, x+BALL_SIZE<=PAD_R_X, nx+BALL_SIZE>=PAD_R_X, and ny+BALL_SIZE>pad_r_y and ny<pad_r_y+PAD_H -> nx=PAD_R_X-BALL_SIZE, dir_x<=0, hit_r.
  - Left paddle, mirrored: dir_x=0, x>=PAD_L_X+PAD_W, nx<=PAD_L_X+PAD_W, y-overlap with pad_l_y -> nx=PAD_L_X+PAD_W, dir_x<=1, hit_l.
  - Miss (only when no paddle hit this frame):
    - dir_x=1 and nx+BALL_SIZE>=SCREEN_W: point_l, score_l+1.
    - dir_x=0 and x<SPEED: point_r, score_r+1.
    - On either miss: ball to (CX,CY), dir_x toward the player who conceded (point_l -> dir_x=1), dir_y kept, serve counter cleared. If the new score equals WIN_SCORE -> OVER, else -> SERVE.
  - A Y bounce and an X event in the same frame both apply; both pulses assert together.
- Scores saturate at WIN_SCORE (2^SCORE_W-1 must be >= WIN_SCORE).
- OVER: game_over=1; ball held; start=1 -> SERVE, scores cleared, game_over 0, dir_x=1.
- Reset asserted mid-game aborts immediately; no partial score update survives.

Test Plan:
- Reset, start=1, 60 ticks -> ball stays (316,236) while state=SERVE. After tick 60, state=PLAY. Next tick -> (318,238).
- Free run, pads at y=0 -> PLAY tick 118: ball_y=472, dir_y=0, wall_hit high one cycle, ball_x=552.
- pad_r_y=400 -> PLAY tick 146: ball_x=608, ball_y=416, dir_x=0, hit_r pulse, no point.
- pad_r_y=0 -> PLAY tick 158: point_l pulse, score_l=1, ball (316,236), dir_x=1, state=SERVE.
- Drive 9 right-side misses -> score_l=9, game_over=1, state=OVER; further ticks change nothing. start -> scores 0, state=SERVE.
- Assert reset between clock edges during PLAY -> all outputs take reset values before the next edge. Scores 0 after release.
